// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the rv32i memory-access / writeback stage.
package rv32_mem_pkg;

  // Writeback source select driven by the control unit.
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_ALU2 = 2'b11;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings.
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores, extension for loads, and access legality flags.
module load_store_align
  import rv32_mem_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [DataWidth-1:0] store_data,
  input  logic [DataWidth-1:0] rdata,
  output logic [3:0]           wmask,
  output logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] load_value,
  output logic                 misaligned,
  output logic                 illegal
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the returned load word.
  always_comb begin
    byte_s = rdata[7:0];
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Decode funct3 into lane mask / replicated data / extended result; loads win if both flags are set.
  always_comb begin
    wmask      = 4'b0000;
    wdata      = store_data;
    load_value = rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_LB:   load_value = {{24{byte_s[7]}}, byte_s};
        F3_LBU:  load_value = {24'h000000, byte_s};
        F3_LH: begin
          load_value = {{16{half_s[15]}}, half_s};
          misaligned = addr_lo[0];
        end
        F3_LHU: begin
          load_value = {16'h0000, half_s};
          misaligned = addr_lo[0];
        end
        F3_LW: begin
          load_value = rdata;
          misaligned = (addr_lo != 2'b00);
        end
        default: illegal = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        F3_SB: begin
          wmask = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata      = {2{store_data[15:0]}};
          misaligned = addr_lo[0];
        end
        F3_SW: begin
          wmask      = 4'b1111;
          wdata      = store_data;
          misaligned = (addr_lo != 2'b00);
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      wmask = 4'b0000;
    end
  end

endmodule

// File: rtl/memory_writeback.sv
// Memory-access and writeback stage: issues data-memory requests and returns
// the registered register-file write triple to decode.
module memory_writeback
  import rv32_mem_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [DataWidth-1:0] instruction,
  input  logic [DataWidth-1:0] pc_address,
  input  logic [DataWidth-1:0] alu_result,
  input  logic [DataWidth-1:0] store_data,
  input  logic                 load,
  input  logic                 store,
  input  logic                 reg_write_en_in,
  input  logic [1:0]           mem_to_reg,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_we,
  output logic [DataWidth-1:0] dmem_addr,
  output logic [DataWidth-1:0] dmem_wdata,
  output logic [3:0]           dmem_wmask,
  input  logic                 dmem_rsp_valid,
  input  logic [DataWidth-1:0] dmem_rdata,
  output logic                 stall,
  output logic                 reg_write_en_out,
  output logic [DataWidth-1:0] rd_wb_data,
  output logic [DataWidth-1:0] instruction_rd,
  output logic                 load_control,
  output logic                 fault
);

  localparam logic [DataWidth-1:0] PcStep = DataWidth'(4);

  state_t                 state_r;
  logic [DataWidth-1:0]   instr_r;
  logic [1:0]             addr_lo_r;
  logic                   load_r;

  logic                   idle_s;
  logic                   al_load_s;
  logic                   al_store_s;
  logic [2:0]             al_funct3_s;
  logic [1:0]             al_addr_lo_s;
  logic [3:0]             wmask_s;
  logic [DataWidth-1:0]   wdata_s;
  logic [DataWidth-1:0]   load_value_s;
  logic                   misaligned_s;
  logic                   illegal_s;
  logic                   rd_nz_s;
  logic                   latched_rd_nz_s;
  logic [DataWidth-1:0]   alu_wb_s;

  // The aligner sees the incoming instruction while idle and the latched load afterwards.
  always_comb begin
    idle_s = (state_r == IDLE);
    if (idle_s) begin
      al_load_s    = load;
      al_store_s   = store;
      al_funct3_s  = instruction[14:12];
      al_addr_lo_s = alu_result[1:0];
    end else begin
      al_load_s    = load_r;
      al_store_s   = 1'b0;
      al_funct3_s  = instr_r[14:12];
      al_addr_lo_s = addr_lo_r;
    end
    rd_nz_s         = (instruction[11:7] != {RegAddress{1'b0}});
    latched_rd_nz_s = (instr_r[11:7] != {RegAddress{1'b0}});
    if (mem_to_reg == WB_PC4) begin
      alu_wb_s = pc_address + PcStep;
    end else begin
      alu_wb_s = alu_result;
    end
  end

  load_store_align #(.DataWidth(DataWidth)) u_align (
    .is_load    (al_load_s),
    .is_store   (al_store_s),
    .funct3     (al_funct3_s),
    .addr_lo    (al_addr_lo_s),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .wmask      (wmask_s),
    .wdata      (wdata_s),
    .load_value (load_value_s),
    .misaligned (misaligned_s),
    .illegal    (illegal_s)
  );

  // Stage FSM with all outputs registered; write strobe and fault are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      instr_r          <= '0;
      addr_lo_r        <= 2'b00;
      load_r           <= 1'b0;
      dmem_req_valid   <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      dmem_wmask       <= 4'b0000;
      stall            <= 1'b0;
      reg_write_en_out <= 1'b0;
      rd_wb_data       <= '0;
      instruction_rd   <= '0;
      load_control     <= 1'b0;
      fault            <= 1'b0;
    end else begin
      reg_write_en_out <= 1'b0;
      fault            <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid) begin
            instr_r   <= instruction;
            addr_lo_r <= alu_result[1:0];
            load_r    <= load;
            if (!(load || store)) begin
              if (reg_write_en_in && rd_nz_s) begin
                reg_write_en_out <= 1'b1;
                rd_wb_data       <= alu_wb_s;
                instruction_rd   <= instruction;
              end
            end else if (misaligned_s || illegal_s) begin
              fault <= 1'b1;
            end else begin
              state_r        <= REQ;
              dmem_req_valid <= 1'b1;
              dmem_we        <= !load;
              dmem_addr      <= {alu_result[DataWidth-1:2], 2'b00};
              dmem_wdata     <= wdata_s;
              dmem_wmask     <= wmask_s;
              stall          <= 1'b1;
              load_control   <= load;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            if (load_r) begin
              state_r <= WAIT;
            end else begin
              state_r <= IDLE;
              stall   <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (dmem_rsp_valid) begin
            state_r      <= IDLE;
            stall        <= 1'b0;
            load_control <= 1'b0;
            if (latched_rd_nz_s) begin
              reg_write_en_out <= 1'b1;
              rd_wb_data       <= load_value_s;
              instruction_rd   <= instr_r;
            end
          end
        end
        default: begin
          state_r        <= IDLE;
          dmem_req_valid <= 1'b0;
          stall          <= 1'b0;
          load_control   <= 1'b0;
        end
      endcase
    end
  end

endmodule
